// File: rtl/block_averager.sv
// block_averager: collects blocks of 2^G_LOG2_NSAMPLES signed samples
// and emits floor mean, minimum and maximum once per block.
module block_averager #(
  parameter int G_LOG2_NSAMPLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        data_in_valid,
  output logic [31:0] avg_out,
  output logic [31:0] min_out,
  output logic [31:0] max_out,
  output logic        avg_out_valid
);

  localparam int N  = 1 << G_LOG2_NSAMPLES;
  localparam int CW = G_LOG2_NSAMPLES + 1;
  localparam int AW = 32 + G_LOG2_NSAMPLES;

  typedef enum logic {
    EMPTY,
    ACCUM
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic [CW-1:0]          count;
  logic [CW-1:0]          count_n;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_n;
  logic signed [31:0]     run_min;
  logic signed [31:0]     run_max;
  logic signed [31:0]     min_n;
  logic signed [31:0]     max_n;
  logic signed [31:0]     sample;
  logic signed [AW-1:0]   sample_ext;
  logic [31:0]            avg_n;
  logic                   done;

  assign sample     = signed'(data_in);
  assign sample_ext = AW'(sample);

  // The accumulator is wide enough that the shifted sum
  // always fits back into 32 bits.
  assign avg_n = 32'(acc_n >>> G_LOG2_NSAMPLES);

  // Next-state: fold an accepted sample into the running stats
  // and detect the sample that closes the block.
  always_comb begin
    state_n = state;
    count_n = count;
    acc_n   = acc;
    min_n   = run_min;
    max_n   = run_max;
    done    = 1'b0;
    if (data_in_valid) begin
      unique case (state)
        EMPTY: begin
          acc_n   = sample_ext;
          min_n   = sample;
          max_n   = sample;
          count_n = CW'(1);
          state_n = ACCUM;
        end
        ACCUM: begin
          acc_n   = acc + sample_ext;
          if (sample < run_min)
            min_n = sample;
          if (sample > run_max)
            max_n = sample;
          count_n = count + CW'(1);
        end
        default: ;
      endcase
      if (count == CW'(N - 1)) begin
        done    = 1'b1;
        count_n = '0;
        state_n = EMPTY;
      end
    end
  end

  // State, running stats and result registers; results only
  // change on the closing sample of a block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EMPTY;
      count         <= '0;
      acc           <= '0;
      run_min       <= '0;
      run_max       <= '0;
      avg_out       <= '0;
      min_out       <= '0;
      max_out       <= '0;
      avg_out_valid <= 1'b0;
    end else begin
      state         <= state_n;
      count         <= count_n;
      acc           <= acc_n;
      run_min       <= min_n;
      run_max       <= max_n;
      avg_out_valid <= done;
      if (done) begin
        avg_out <= avg_n;
        min_out <= min_n;
        max_out <= max_n;
      end
    end
  end

endmodule

// File: tb/tb_block_averager.sv
// tb_block_averager: random and directed stimulus on N=4 and N=1
// instances, checked against a queue-based reference model.
module tb_block_averager;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin = 1'b0;
  logic [31:0] din = '0;

  logic [31:0] avg0, min0, max0;
  logic        v0;
  logic [31:0] avg1, min1, max1;
  logic        v1;

  always #5 clk = ~clk;

  block_averager #(.G_LOG2_NSAMPLES(2)) dut4 (
    .clk(clk), .rst(rst),
    .data_in(din), .data_in_valid(vin),
    .avg_out(avg0), .min_out(min0),
    .max_out(max0), .avg_out_valid(v0)
  );

  block_averager #(.G_LOG2_NSAMPLES(0)) dut1 (
    .clk(clk), .rst(rst),
    .data_in(din), .data_in_valid(vin),
    .avg_out(avg1), .min_out(min1),
    .max_out(max1), .avg_out_valid(v1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit armed    = 1'b0;

  logic signed [31:0] q4[$];
  logic signed [31:0] q1[$];
  logic [31:0] e_avg[2];
  logic [31:0] e_min[2];
  logic [31:0] e_max[2];
  logic        e_v[2];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)",
               name, $signed(got), got, $signed(exp), exp);
  endtask

  // floor mean, min and max of a finished block
  function automatic void calc(input logic signed [31:0] q[$],
                               output logic [31:0] a,
                               output logic [31:0] mn,
                               output logic [31:0] mx);
    longint s = 0;
    longint n = longint'(q.size());
    longint m;
    logic signed [31:0] lo = q[0];
    logic signed [31:0] hi = q[0];
    foreach (q[i]) begin
      s += longint'(q[i]);
      if (q[i] < lo) lo = q[i];
      if (q[i] > hi) hi = q[i];
    end
    m = s / n;
    if ((s % n) != 0 && s < 0)
      m = m - 1;
    a  = m[31:0];
    mn = lo;
    mx = hi;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      armed = 1'b1;
      q4.delete();
      e_avg[0] = '0; e_min[0] = '0; e_max[0] = '0;
      e_v[0] = 1'b0;
    end else begin
      e_v[0] = 1'b0;
      if (vin) begin
        q4.push_back(din);
        if (q4.size() == 4) begin
          calc(q4, e_avg[0], e_min[0], e_max[0]);
          e_v[0] = 1'b1;
          q4.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      q1.delete();
      e_avg[1] = '0; e_min[1] = '0; e_max[1] = '0;
      e_v[1] = 1'b0;
    end else begin
      e_v[1] = 1'b0;
      if (vin) begin
        q1.push_back(din);
        calc(q1, e_avg[1], e_min[1], e_max[1]);
        e_v[1] = 1'b1;
        q1.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("n4_avg",   avg0, e_avg[0]);
      chk("n4_min",   min0, e_min[0]);
      chk("n4_max",   max0, e_max[0]);
      chk("n4_valid", 32'(v0), 32'(e_v[0]));
      chk("n1_avg",   avg1, e_avg[1]);
      chk("n1_min",   min1, e_min[1]);
      chk("n1_max",   max1, e_max[1]);
      chk("n1_valid", 32'(v1), 32'(e_v[1]));
    end
  end

  task automatic send(input logic v, input logic [31:0] d);
    vin = v;
    din = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, $urandom);
  endtask

  function automatic logic [31:0] rnd_data();
    int unsigned r = $urandom_range(0, 9);
    if (r == 0) return 32'h7FFF_FFFF;
    if (r == 1) return 32'h8000_0000;
    if (r < 5)  return 32'($urandom_range(0, 20)) - 32'd10;
    return $urandom;
  endfunction

  task automatic lit(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] mn,
                     input logic [31:0] mx);
    chk({tag, "_avg"}, avg0, a);
    chk({tag, "_min"}, min0, mn);
    chk({tag, "_max"}, max0, mx);
    chk({tag, "_strobe"}, 32'(v0), 32'd1);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    repeat (3) send(1'($urandom_range(0, 1)), $urandom);
    chk("rst_avg", avg0, 32'd0);
    chk("rst_valid", 32'(v0), 32'd0);
    rst = 1'b0;

    send(1, 10); send(1, 20); send(1, 30); send(1, 40);
    lit("basic", 25, 10, 40);
    idle(1);
    chk("basic_once", 32'(v0), 32'd0);

    send(1, 5); send(0, 999); send(1, 7); send(1, 9);
    idle(2);
    send(1, 3);
    lit("gaps", 6, 3, 9);

    send(1, -32'sd1); send(1, -32'sd2);
    send(1, -32'sd3); send(1, -32'sd3);
    lit("neg", -32'sd3, -32'sd3, -32'sd1);

    repeat (4) send(1, 32'h7FFF_FFFF);
    lit("maxpos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    repeat (3) send(1, 32'h8000_0000);
    chk("extreme_gap", 32'(v0), 32'd0);
    send(1, 32'h8000_0000);
    lit("maxneg", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);

    send(1, 100); send(1, 200);
    rst = 1'b1;
    send(1, 77);
    rst = 1'b0;
    send(1, 1); send(1, 2); send(1, 3);
    chk("midrst_nostrobe", 32'(v0), 32'd0);
    send(1, 4);
    lit("midrst", 2, 1, 4);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      d = rnd_data();
      send(1, d);
      chk("echo_avg", avg1, d);
      chk("echo_max", max1, d);
      chk("echo_strobe", 32'(v1), 32'd1);
    end

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      send(1'($urandom_range(0, 9) < 7), rnd_data());
    end
    rst = 1'b0;
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/block_averager.md
# block_averager

Downstream consumer of the delay-then-subtract stage's `data_out`/`data_out_valid` stream. Collects blocks of 2^G_LOG2_NSAMPLES valid signed samples and emits, once per block, the block mean (floor), minimum and maximum. The result is a registered output strobe for the next stage or for a Verilator testbench.

## Interface
- `G_LOG2_NSAMPLES`, default 2: block length N = 2^G_LOG2_NSAMPLES; legal range 0..8.
- `clk`  input  1  rising-edge clock for all state.
- `rst`  input  1  reset, synchronous and active-high; one clock, no other clock domains.
- `data_in`  input  32  sample, signed two's complement; sampled only when `data_in_valid`=1.
- `data_in_valid`  input  1  sample qualifier; no backpressure, every valid sample is accepted.
- `avg_out`  output  32  signed floor mean of the last completed block.
- `min_out`  output  32  signed minimum of the last completed block.
- `max_out`  output  32  signed maximum of the last completed block.
- `avg_out_valid`  output  1  one-cycle strobe: `avg_out`/`min_out`/`max_out` updated this cycle.

## Operation
- Internal state:
  - `count`: G_LOG2_NSAMPLES+1 bits, samples accepted in the current block.
  - `acc`: signed, 32+G_LOG2_NSAMPLES bits, so it cannot overflow.
  - `run_min` and `run_max`: signed 32 bits.
- Two states:
  - EMPTY (`count`=0).
  - ACCUM (0<`count`<N).
- EMPTY, valid sample arrives:
  - `acc`=sign-extended `data_in`; `run_min`=`run_max`=`data_in`.
  - `count`=1, go to ACCUM.
  - If N=1, this is also the last sample (see below).
- ACCUM, valid sample arrives:
  - `acc`+=`data_in`; `run_min`/`run_max` updated by signed compare.
  - `count`+=1.
- Last sample of a block (`count`=N-1 before the accept, or N=1):
  - Registers `avg_out` = (`acc`+`data_in`) >>> G_LOG2_NSAMPLES, truncated to 32 bits. The result always fits.
  - Registers `min_out`/`max_out` including the final sample.
  - Pulses `avg_out_valid`.
  - Returns to EMPTY with `count`=0.
- `data_in_valid`=0: no state change; `data_in` ignored, X on `data_in` is harmless.
- Rounding is arithmetic shift, i.e. toward negative infinity, not toward zero.
- Outputs hold their values between strobes.

## Timing
- Latency: the strobe occurs 1 cycle after the edge that accepts the Nth sample, i.e. registered on that edge.
- Back-to-back blocks:
  - A valid sample on the cycle after completion starts the next block from EMPTY. No bubble is required.
  - Throughput is 1 sample/cycle.
  - Strobes can occur at most every N cycles; for N=1, every cycle.
- `avg_out_valid` is high for exactly one cycle per completed block, never otherwise.
- Reset (`rst`=1 at an edge):
  - `count`=0, state EMPTY.
  - `acc`, `run_min`, `run_max` = 0.
  - `avg_out`, `min_out`, `max_out` = 0; `avg_out_valid`=0.
  - A valid sample in a reset cycle is discarded.
- Reset mid-block: the partial block is discarded with no strobe. The next valid sample after reset release starts a new block.
- Equal values: when a sample equals `run_min`/`run_max`, either update is acceptable since the result is identical.

## Test plan
- Reset: hold `rst` 3 cycles with random valid data. All outputs stay 0, `avg_out_valid` never high, and the first block after release is correct.
- Basic block, N=4, back-to-back samples 10, 20, 30, 40. One cycle after 40 is accepted: `avg_out`=25, `min_out`=10, `max_out`=40, `avg_out_valid` high for 1 cycle.
- Gaps and ignored data, N=4: samples 5, (valid=0, `data_in`=999), 7, 9, (2 idle cycles), 3. Strobe fires after 3 with `avg_out`=6, `min_out`=3, `max_out`=9. The value 999 must not appear.
- Negative and floor rounding, N=4: samples -1, -2, -3, -3 give `avg_out`=-3 (floor of -2.25), `min_out`=-3, `max_out`=-1.
- Extremes, no overflow, N=4:
  - 4× 0x7FFFFFFF gives `avg_out`=0x7FFFFFFF.
  - Immediately following, 4× 0x80000000 gives `avg_out`=0x80000000.
  - Two strobes exactly 4 cycles apart.
- Reset mid-block and N=1:
  - N=4: samples 100, 200, then `rst` 1 cycle, then 1, 2, 3, 4. Exactly one strobe, with `avg_out`=2, `min_out`=1, `max_out`=4.
  - Separately, G_LOG2_NSAMPLES=0 with 8 consecutive samples: each is echoed on all three outputs 1 cycle later, with `avg_out_valid` continuously high.
